glitc_phi_trigger: RTL and testbench

- Trigger decision stage that consumes the per-RITC max-power words produced by the dual RITC correlator (R0_MAX/R1_MAX) and the neighbour-phi power and valid words recovered by the GLITC intercom.
- Forms local and neighbour-coincidence triggers, applies holdoff, and keeps per-RITC hit scalers.
- Runs entirely in the SYSCLK (162.5 MHz) domain and sits behind the trigger register window (0x0070-0x007F).
- A gb_clk-side register shim supplies the quasi-static thresholds and latches the scaler outputs; that shim is not part of this block.

---
 rtl/glitc_phi_trigger.sv | 232 +++++++++++++++++++++++
 tb/tb_glitc_phi_trigger.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_phi_trigger.sv
// GLITC phi-sector trigger: local and neighbour-coincidence triggers with holdoff and per-RITC hit scalers.
// Optional summed-power trigger type is enabled by defining GLITC_TRIG_SUM_EN.
module glitc_phi_trigger #(
    parameter int PWR_BITS  = 11,
    parameter int WINDOW    = 4,
    parameter int SCAL_BITS = 16
) (
    input  logic                 sysclk_i,
    input  logic                 rst_i,
    input  logic                 sync_i,
    input  logic [PWR_BITS-1:0]  r0_power_i,
    input  logic [PWR_BITS-1:0]  r1_power_i,
    input  logic [PWR_BITS-1:0]  phi_up_power_i,
    input  logic                 phi_up_valid_i,
    input  logic [PWR_BITS-1:0]  phi_down_power_i,
    input  logic                 phi_down_valid_i,
    input  logic [PWR_BITS-1:0]  r0_thresh_i,
    input  logic [PWR_BITS-1:0]  r1_thresh_i,
    input  logic [PWR_BITS-1:0]  nbr_thresh_i,
    input  logic [PWR_BITS:0]    sum_thresh_i,
    input  logic [3:0]           trig_mask_i,
    input  logic [7:0]           holdoff_i,
    input  logic [23:0]          scal_period_i,
    output logic                 trig_o,
    output logic [3:0]           trig_type_o,
    output logic [SCAL_BITS-1:0] r0_scaler_o,
    output logic [SCAL_BITS-1:0] r1_scaler_o,
    output logic                 scal_valid_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_ARMED     = 2'd1,
        ST_HOLDOFF   = 2'd2,
        ST_UNUSED    = 2'd3
    } state_t;

    localparam logic [3:0]           WIN      = 4'(WINDOW);
    localparam logic [SCAL_BITS-1:0] SCAL_MAX = '1;

    // Stage 1: input registers
    logic [PWR_BITS-1:0] r0_q, r1_q, up_pwr_q, dn_pwr_q;
    logic                up_vld_q, dn_vld_q;

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            r0_q     <= '0;
            r1_q     <= '0;
            up_pwr_q <= '0;
            dn_pwr_q <= '0;
            up_vld_q <= 1'b0;
            dn_vld_q <= 1'b0;
        end else begin
            r0_q     <= r0_power_i;
            r1_q     <= r1_power_i;
            up_pwr_q <= phi_up_power_i;
            dn_pwr_q <= phi_down_power_i;
            up_vld_q <= phi_up_valid_i;
            dn_vld_q <= phi_down_valid_i;
        end
    end

    // Stage 2: threshold comparisons
    logic [1:0] hit_q, hit_d;
    logic       nup_q, nup_d, ndn_q, ndn_d;
    logic       sum_hit_q, sum_hit_d;

    always_comb begin
        hit_d[0] = r0_q >= r0_thresh_i;
        hit_d[1] = r1_q >= r1_thresh_i;
        nup_d    = up_vld_q && (up_pwr_q >= nbr_thresh_i);
        ndn_d    = dn_vld_q && (dn_pwr_q >= nbr_thresh_i);
`ifdef GLITC_TRIG_SUM_EN
        sum_hit_d = ({1'b0, r0_q} + {1'b0, r1_q}) >= sum_thresh_i;
`else
        sum_hit_d = 1'b0 & (|sum_thresh_i);
`endif
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q     <= '0;
            nup_q     <= 1'b0;
            ndn_q     <= 1'b0;
            sum_hit_q <= 1'b0;
        end else begin
            hit_q     <= hit_d;
            nup_q     <= nup_d;
            ndn_q     <= ndn_d;
            sum_hit_q <= sum_hit_d;
        end
    end

    // Neighbour stretchers: reload to WINDOW on a hit, otherwise count down to zero
    logic [1:0] nbr_hit;
    logic [3:0] str_cnt_q [2];
    logic [1:0] str_busy;

    assign nbr_hit = {ndn_q, nup_q};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stretch
            always_ff @(posedge sysclk_i or posedge rst_i) begin
                if (rst_i) begin
                    str_cnt_q[gi] <= '0;
                end else if (nbr_hit[gi]) begin
                    str_cnt_q[gi] <= WIN;
                end else if (str_cnt_q[gi] != 4'd0) begin
                    str_cnt_q[gi] <= str_cnt_q[gi] - 4'd1;
                end
            end
            assign str_busy[gi] = str_cnt_q[gi] != 4'd0;
        end
    endgenerate

    logic [3:0] type_raw, type_masked;
    logic       fire;

    always_comb begin
        type_raw[0] = hit_q[0];
        type_raw[1] = hit_q[1];
        type_raw[2] = (hit_q[0] || hit_q[1]) && (nup_q || ndn_q || (|str_busy));
        type_raw[3] = sum_hit_q;
        type_masked = type_raw & trig_mask_i;
        fire        = |type_masked;
    end

    // Trigger FSM; outputs are registered, forming the third pipeline stage
    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       trig_q, trig_d;
    logic [3:0] type_q, type_d;

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_WAIT_SYNC;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            type_q  <= type_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        trig_d  = 1'b0;
        type_d  = type_q;
        case (state_q)
            ST_WAIT_SYNC: begin
                if (sync_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (fire) begin
                    trig_d = 1'b1;
                    type_d = type_masked;
                    hold_d = holdoff_i;
                    if (holdoff_i != 8'd0) state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                hold_d = hold_q - 8'd1;
                if (hold_q <= 8'd1) state_d = ST_ARMED;
            end
            default: state_d = ST_WAIT_SYNC;
        endcase
    end

    // Scaler gate: free-running from the first sync, independent of the trigger FSM
    logic        started_q;
    logic [23:0] gate_q, gate_d;
    logic        gate_en, gate_last, gate_over;
    logic        sv_q;

    always_comb begin
        gate_en   = started_q && (scal_period_i != 24'd0);
        gate_last = gate_en && (gate_q == scal_period_i - 24'd1);
        gate_over = gate_en && (gate_q >= scal_period_i);
        if (!gate_en || gate_last || gate_over) begin
            gate_d = '0;
        end else begin
            gate_d = gate_q + 24'd1;
        end
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            started_q <= 1'b0;
            gate_q    <= '0;
            sv_q      <= 1'b0;
        end else begin
            if (sync_i) started_q <= 1'b1;
            gate_q <= gate_d;
            sv_q   <= gate_last;
        end
    end

    logic [SCAL_BITS-1:0] cnt_q  [2];
    logic [SCAL_BITS-1:0] scal_q [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_scaler
            // A hit in the latch cycle seeds the next gate's count
            always_ff @(posedge sysclk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q[gi]  <= '0;
                    scal_q[gi] <= '0;
                end else if (gate_en) begin
                    if (gate_last) begin
                        scal_q[gi] <= cnt_q[gi];
                        cnt_q[gi]  <= {{(SCAL_BITS-1){1'b0}}, hit_q[gi]};
                    end else if (hit_q[gi] && (cnt_q[gi] != SCAL_MAX)) begin
                        cnt_q[gi] <= cnt_q[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign trig_o       = trig_q;
    assign trig_type_o  = type_q;
    assign r0_scaler_o  = scal_q[0];
    assign r1_scaler_o  = scal_q[1];
    assign scal_valid_o = sv_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_glitc_phi_trigger.sv
// Directed bench for glitc_phi_trigger: latency, holdoff, neighbour coincidence, sum type, scalers, reset.
module tb_glitc_phi_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync;
    logic [10:0] r0_power, r1_power, up_power, dn_power;
    logic        up_valid, dn_valid;
    logic [10:0] r0_thresh, r1_thresh, nbr_thresh;
    logic [11:0] sum_thresh;
    logic [3:0]  trig_mask;
    logic [7:0]  holdoff;
    logic [23:0] scal_period;
    logic        trig_o;
    logic [3:0]  trig_type_o;
    logic [15:0] r0_scaler_o, r1_scaler_o;
    logic        scal_valid_o;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    glitc_phi_trigger #(.PWR_BITS(11), .WINDOW(4), .SCAL_BITS(16)) dut (
        .sysclk_i        (clk),
        .rst_i           (rst),
        .sync_i          (sync),
        .r0_power_i      (r0_power),
        .r1_power_i      (r1_power),
        .phi_up_power_i  (up_power),
        .phi_up_valid_i  (up_valid),
        .phi_down_power_i(dn_power),
        .phi_down_valid_i(dn_valid),
        .r0_thresh_i     (r0_thresh),
        .r1_thresh_i     (r1_thresh),
        .nbr_thresh_i    (nbr_thresh),
        .sum_thresh_i    (sum_thresh),
        .trig_mask_i     (trig_mask),
        .holdoff_i       (holdoff),
        .scal_period_i   (scal_period),
        .trig_o          (trig_o),
        .trig_type_o     (trig_type_o),
        .r0_scaler_o     (r0_scaler_o),
        .r1_scaler_o     (r1_scaler_o),
        .scal_valid_o    (scal_valid_o),
        .state_o         (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sv(input int limit, output int n);
        n = 0;
        while (!scal_valid_o && n < limit) begin
            tick();
            n++;
        end
    endtask

    int seen, n, elapsed, cnt, hi;
    int p [3];
    logic exp_sum;

    initial begin
        rst = 1'b1; sync = 1'b0;
        r0_power = '0; r1_power = '0; up_power = '0; dn_power = '0;
        up_valid = 1'b0; dn_valid = 1'b0;
        r0_thresh = 11'd400; r1_thresh = 11'd400; nbr_thresh = 11'd300;
        sum_thresh = 12'd3000; trig_mask = 4'b0001; holdoff = 8'd0; scal_period = '0;
        tick(); tick();
        check("rst_trig", trig_o, 0);
        check("rst_type", trig_type_o, 0);
        check("rst_state", state_o, 0);
        check("rst_sv", scal_valid_o, 0);
        rst = 1'b0;

        // no trigger before the first sync
        r0_power = 11'd500;
        seen = 0;
        repeat (10) begin tick(); if (trig_o) seen = 1; end
        check("nosync_trig", seen, 0);
        check("nosync_state", state_o, 0);
        r0_power = '0;
        repeat (3) tick();
        sync = 1'b1; tick(); sync = 1'b0;
        check("armed_state", state_o, 1);
        repeat (3) tick();

        // three-cycle latency
        r0_power = 11'd500; tick(); r0_power = '0;
        check("lat_c1", trig_o, 0);
        tick(); check("lat_c2", trig_o, 0);
        tick(); check("lat_c3", trig_o, 1);
        check("lat_type", trig_type_o, 4'b0001);
        tick(); check("lat_c4", trig_o, 0);
        check("type_hold", trig_type_o, 4'b0001);

        // threshold equality is a hit
        repeat (3) tick();
        r0_power = 11'd400; tick(); r0_power = '0; tick(); tick();
        check("eq_thresh", trig_o, 1);

        // holdoff 5: pulse every 6 cycles
        repeat (3) tick();
        holdoff = 8'd5; r0_power = 11'd500; cnt = 0;
        for (int c = 0; c < 40 && cnt < 3; c++) begin
            tick();
            if (trig_o) begin p[cnt] = c; cnt++; end
        end
        check("ho_pulses", cnt, 3);
        check("ho_gap1", p[1] - p[0], 6);
        check("ho_gap2", p[2] - p[1], 6);
        holdoff = 8'd0;
        repeat (10) tick();
        hi = 0;
        repeat (10) begin tick(); if (trig_o) hi++; end
        check("ho0_every", hi, 10);
        r0_power = '0;
        repeat (6) tick();

        // neighbour coincidence: hit 4 cycles after up neighbour
        trig_mask = 4'b0100;
        up_power = 11'd300; up_valid = 1'b1; tick(); up_valid = 1'b0; up_power = '0;
        repeat (3) tick();
        r1_power = 11'd500; tick(); r1_power = '0; tick(); tick();
        check("coin4_trig", trig_o, 1);
        check("coin4_type", trig_type_o, 4'b0100);
        repeat (10) tick();
        // 5 cycles later is outside the window
        up_power = 11'd300; up_valid = 1'b1; tick(); up_valid = 1'b0; up_power = '0;
        repeat (4) tick();
        r1_power = 11'd500; tick(); r1_power = '0;
        seen = 0;
        repeat (6) begin tick(); if (trig_o) seen = 1; end
        check("coin5_trig", seen, 0);
        repeat (6) tick();
        // down neighbour in the same cycle
        dn_power = 11'd400; dn_valid = 1'b1; r1_power = 11'd500; tick();
        dn_valid = 1'b0; dn_power = '0; r1_power = '0; tick(); tick();
        check("coin_dn_trig", trig_o, 1);
        repeat (10) tick();
        // strong neighbour power without valid does not count
        up_power = 11'd2000; up_valid = 1'b0; r1_power = 11'd500; tick();
        up_power = '0; r1_power = '0;
        seen = 0;
        repeat (6) begin tick(); if (trig_o) seen = 1; end
        check("coin_novalid", seen, 0);

        // summed power type
`ifdef GLITC_TRIG_SUM_EN
        exp_sum = 1'b1;
`else
        exp_sum = 1'b0;
`endif
        r0_thresh = 11'd2047; r1_thresh = 11'd2047; trig_mask = 4'b1000;
        r0_power = 11'd1500; r1_power = 11'd1500; tick();
        r0_power = '0; r1_power = '0; tick(); tick();
        check("sum_trig", trig_o, exp_sum);
        if (exp_sum) check("sum_type", trig_type_o, 4'b1000);
        repeat (4) tick();
        r0_power = 11'd1499; r1_power = 11'd1499; tick();
        r0_power = '0; r1_power = '0; tick(); tick();
        check("sum_below", trig_o, 0);
        r0_thresh = 11'd400; r1_thresh = 11'd400; trig_mask = 4'b0000;
        repeat (4) tick();

        // scalers: 250 hits in a 1000-cycle gate
        scal_period = 24'd1000;
        wait_sv(1100, n);
        check("sv_first_seen", n < 1100, 1);
        tick(); repeat (9) tick();
        r0_power = 11'd500;
        repeat (250) tick();
        r0_power = '0;
        elapsed = 260;
        wait_sv(1000, n);
        check("sv_interval", elapsed + n, 1000);
        check("r0_scaler_250", r0_scaler_o, 250);
        check("r1_scaler_0", r1_scaler_o, 0);
        tick();
        check("sv_one_cycle", scal_valid_o, 0);

        // saturation with a long gate
        scal_period = 24'd70000; r0_power = 11'd500;
        wait_sv(71000, n);
        check("sat_seen", n < 71000, 1);
        check("r0_scaler_sat", r0_scaler_o, 16'hFFFF);

        // reset during holdoff with a gate in progress
        tick();
        scal_period = 24'd100; holdoff = 8'd50; trig_mask = 4'b0001;
        n = 0;
        while (state_o != 2'd2 && n < 20) begin tick(); n++; end
        check("in_holdoff", state_o, 2);
        repeat (20) tick();
        #3 rst = 1'b1;
        #1;
        check("arst_trig", trig_o, 0);
        check("arst_type", trig_type_o, 0);
        check("arst_sc0", r0_scaler_o, 0);
        check("arst_sv", scal_valid_o, 0);
        check("arst_state", state_o, 0);
        @(posedge clk); #2 rst = 1'b0;
        seen = 0;
        repeat (150) begin tick(); if (scal_valid_o || trig_o) seen = 1; end
        check("presync_quiet", seen, 0);
        sync = 1'b1; tick(); sync = 1'b0;
        wait_sv(110, n);
        check("rs_sv_seen", n < 110, 1);
        check("rs_first_cnt", (r0_scaler_o >= 16'd99 && r0_scaler_o <= 16'd100), 1);
        tick();
        wait_sv(110, n);
        check("rs_interval", n + 1, 100);
        check("rs_full_cnt", r0_scaler_o, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
